performance_avg_capture: RTL

- Consumer stage for one performance-counter channel (prog, read or erase).
- When the counter signals its window is full (ready high), this block:
  - latches the accumulated latency sum and the request count;
  - computes the floor average with a sequential restoring divider;
  - publishes sum, count and average to the slave register file;
  - returns a one-cycle copy-complete pulse so the counter can clear and restart.
- One instance per channel; REQ_WD is 10 for prog/erase and 12 for read.

---
 rtl/performance_avg_capture_if.sv | 16 +
 rtl/performance_avg_capture.sv | 125 ++++++++++++
 2 files changed

// File: rtl/performance_avg_capture_if.sv
// Counter-to-capture handshake: the counter presents a full window
// (ready + sum + count) and waits for the one-cycle copy-complete pulse.
interface performance_avg_capture_if #(
   parameter int SUM_WD = 32,
   parameter int REQ_WD = 10
);
   logic              ready;
   logic [SUM_WD-1:0] sum;
   logic [REQ_WD-1:0] req_cnt;
   logic              cp_cmplt;

   // Counter side: owns the window, consumes the copy-complete pulse.
   modport master (output ready, output sum, output req_cnt, input cp_cmplt);
   // Capture side: samples the window, returns the pulse.
   modport slave  (input ready, input sum, input req_cnt, output cp_cmplt);
endinterface

// File: rtl/performance_avg_capture.sv
// Per-channel performance capture: latches a finished counter window,
// computes floor(sum / count) with a restoring divider (one quotient bit
// per cycle, MSB first) and publishes sum/count/average to the register file.
module performance_avg_capture #(
   parameter int SUM_WD = 32,
   parameter int REQ_WD = 10,
   parameter int CAP_WD = 16
) (
   input  logic                      i_bus_clk,
   input  logic                      i_bus_rst,
   performance_avg_capture_if.slave  bus,
   input  logic                      i_clear,
   output logic [SUM_WD-1:0]         o_sum,
   output logic [REQ_WD-1:0]         o_req_cnt,
   output logic [SUM_WD-1:0]         o_avg,
   output logic                      o_avg_valid,
   output logic [CAP_WD-1:0]         o_capture_cnt,
   output logic                      o_busy
);
   localparam int ITW = (SUM_WD > 1) ? $clog2(SUM_WD) : 1;
   localparam logic [ITW-1:0] LAST_ITER = ITW'(SUM_WD - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE, S_WAIT_LOW} state_t;

   state_t            r_state;
   logic [SUM_WD-1:0] r_sum_lat;   // original sum, kept for publishing
   logic [SUM_WD-1:0] r_dvd;       // dividend shifting out, quotient shifting in
   logic [REQ_WD-1:0] r_dvs;       // latched count (divisor)
   logic [REQ_WD-1:0] r_rem;       // remainder always < divisor, so REQ_WD bits hold it
   logic [ITW-1:0]    r_iter;
   logic              r_cp_cmplt;

   logic [SUM_WD-1:0] r_sum;
   logic [REQ_WD-1:0] r_req_cnt;
   logic [SUM_WD-1:0] r_avg;
   logic              r_avg_valid;
   logic [CAP_WD-1:0] r_capture_cnt;

   logic [REQ_WD:0]   w_rem_sh;    // partial remainder after shifting in the next dividend bit
   logic [REQ_WD:0]   w_diff;
   logic              w_ge;
   logic [SUM_WD-1:0] w_avg;

   // Trial subtraction. w_rem_sh < 2*divisor, so the difference lies in
   // (-2^REQ_WD, 2^REQ_WD) and its top bit is a clean sign/borrow flag.
   assign w_rem_sh = {r_rem, r_dvd[SUM_WD-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_ge     = ~w_diff[REQ_WD];
   // A zero count skips division entirely and reports 0.
   assign w_avg    = (r_dvs == '0) ? '0 : r_dvd;

   // Control FSM and divider datapath; operands are frozen once latched.
   always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
      if (i_bus_rst) begin
         r_state    <= S_IDLE;
         r_sum_lat  <= '0;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_rem      <= '0;
         r_iter     <= '0;
         r_cp_cmplt <= 1'b0;
      end else begin
         r_cp_cmplt <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.ready) begin
                  r_sum_lat <= bus.sum;
                  r_dvd     <= bus.sum;
                  r_dvs     <= bus.req_cnt;
                  r_rem     <= '0;
                  r_iter    <= '0;
                  r_state   <= (bus.req_cnt == '0) ? S_DONE : S_DIV;
               end
            end
            S_DIV: begin
               r_rem  <= w_ge ? w_diff[REQ_WD-1:0] : w_rem_sh[REQ_WD-1:0];
               r_dvd  <= {r_dvd[SUM_WD-2:0], w_ge};
               r_iter <= r_iter + 1'b1;
               if (r_iter == LAST_ITER) r_state <= S_DONE;
            end
            S_DONE: begin
               r_cp_cmplt <= 1'b1;
               r_state    <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               // The counter may hold ready a few cycles after the pulse;
               // only a low level re-arms capture.
               if (!bus.ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Published result registers; a clear in the DONE cycle wins over the update.
   always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
      if (i_bus_rst) begin
         r_sum         <= '0;
         r_req_cnt     <= '0;
         r_avg         <= '0;
         r_avg_valid   <= 1'b0;
         r_capture_cnt <= '0;
      end else if (i_clear) begin
         r_sum         <= '0;
         r_req_cnt     <= '0;
         r_avg         <= '0;
         r_avg_valid   <= 1'b0;
         r_capture_cnt <= '0;
      end else if (r_state == S_DONE) begin
         r_sum         <= r_sum_lat;
         r_req_cnt     <= r_dvs;
         r_avg         <= w_avg;
         r_avg_valid   <= 1'b1;
         r_capture_cnt <= r_capture_cnt + 1'b1;
      end
   end

   assign bus.cp_cmplt  = r_cp_cmplt;
   assign o_sum         = r_sum;
   assign o_req_cnt     = r_req_cnt;
   assign o_avg         = r_avg;
   assign o_avg_valid   = r_avg_valid;
   assign o_capture_cnt = r_capture_cnt;
   assign o_busy        = (r_state != S_IDLE);
endmodule
